// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array matrix-multiply sequencer.
package sa_pkg;

    localparam int unsigned SA_ARRAY_SIZE = 4;
    localparam int unsigned SA_OPND_W     = 8;
    localparam int unsigned SA_ACC_W      = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        OUTPUT
    } sa_seq_state_e;

endpackage

// File: rtl/sa_mm_sequencer_if.sv
// Job, operand-buffer, array-control and result handshake bundle of the sequencer.
interface sa_mm_sequencer_if #(
    parameter int unsigned ARRAY_SIZE = sa_pkg::SA_ARRAY_SIZE,
    parameter int unsigned K_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH = 8
);
    localparam int unsigned ROW_W = $clog2(ARRAY_SIZE);

    logic                  start_v_i;
    logic                  start_ready_o;
    logic [K_WIDTH-1:0]    k_len_i;
    logic [ADDR_WIDTH-1:0] a_base_i;
    logic [ADDR_WIDTH-1:0] b_base_i;
    logic                  abort_i;
    logic                  pe_clear_o;
    logic                  rd_en_o;
    logic [ADDR_WIDTH-1:0] a_addr_o;
    logic [ADDR_WIDTH-1:0] b_addr_o;
    logic [ARRAY_SIZE-1:0] lane_en_o;
    logic                  result_v_o;
    logic                  result_ready_i;
    logic [ROW_W-1:0]      result_row_o;
    logic                  busy_o;
    logic                  done_o;

    // Front end, array and result consumer side
    modport master (
        output start_v_i, k_len_i, a_base_i, b_base_i, abort_i, result_ready_i,
        input  start_ready_o, pe_clear_o, rd_en_o, a_addr_o, b_addr_o, lane_en_o,
               result_v_o, result_row_o, busy_o, done_o
    );

    // Sequencer side
    modport slave (
        input  start_v_i, k_len_i, a_base_i, b_base_i, abort_i, result_ready_i,
        output start_ready_o, pe_clear_o, rd_en_o, a_addr_o, b_addr_o, lane_en_o,
               result_v_o, result_row_o, busy_o, done_o
    );

endinterface

// File: rtl/sa_lane_mask.sv
// Skewed per-lane operand-valid mask: lane r is live while 0 <= t-r < K.
module sa_lane_mask #(
    parameter int unsigned ARRAY_SIZE = 4,
    parameter int unsigned K_WIDTH    = 8,
    parameter int unsigned T_WIDTH    = 11
) (
    input  logic [T_WIDTH-1:0]    t_i,
    input  logic [K_WIDTH-1:0]    k_len_i,
    output logic [ARRAY_SIZE-1:0] lane_en_c
);

    for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_lane
        assign lane_en_c[r] = (t_i >= T_WIDTH'(r)) &&
                              ((t_i - T_WIDTH'(r)) < T_WIDTH'(k_len_i));
    end

endmodule

// File: rtl/sa_mm_sequencer.sv
// Sequences one matrix-multiply pass: clear accumulators, feed skewed operands,
// wait out the pipeline drain, then hand result rows downstream.
module sa_mm_sequencer
    import sa_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE   = SA_ARRAY_SIZE,
    parameter int unsigned K_WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic               clk_i,
    input  logic               reset,
    sa_mm_sequencer_if.slave   bus
);

    localparam int unsigned ROW_W = $clog2(ARRAY_SIZE);
    localparam int unsigned TW    = K_WIDTH + $clog2(ARRAY_SIZE) + 1;
    localparam int unsigned DW    = $clog2(DRAIN_CYCLES + 1);

    sa_seq_state_e         state_q, state_d;
    logic [TW-1:0]         t_q, t_d, t_last_c;
    logic [K_WIDTH-1:0]    k_q, k_d;
    logic [ADDR_WIDTH-1:0] a_base_q, a_base_d, b_base_q, b_base_d;
    logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
    logic [DW-1:0]         drain_q, drain_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [ARRAY_SIZE-1:0] lane_q, lane_d, lane_mask_c;
    logic                  done_q, done_d, clr_q, clr_d, rd_q, rd_d;
    logic                  rv_q, rv_d, rdy_q, rdy_d, busy_q, busy_d;

    assign t_last_c = TW'(k_q) + TW'(ARRAY_SIZE - 2);

    sa_lane_mask #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .K_WIDTH    (K_WIDTH),
        .T_WIDTH    (TW)
    ) u_lane_mask (
        .t_i       (t_d),
        .k_len_i   (k_q),
        .lane_en_c (lane_mask_c)
    );

    // Next state and counters
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        k_d      = k_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        drain_d  = drain_q;
        row_d    = row_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_v_i) begin
                    k_d      = bus.k_len_i;
                    a_base_d = bus.a_base_i;
                    b_base_d = bus.b_base_i;
                    if (bus.k_len_i == '0) done_d  = 1'b1;
                    else                   state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = FEED;
                t_d     = '0;
            end
            FEED: begin
                if (t_q == t_last_c) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            DRAIN: begin
                if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
                    state_d = OUTPUT;
                    row_d   = '0;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            OUTPUT: begin
                if (bus.result_ready_i) begin
                    if (row_q == ROW_W'(ARRAY_SIZE - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort beats a same-cycle result handshake and swallows done
        if (bus.abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
            done_d  = 1'b0;
            row_d   = '0;
        end
    end

    // Registered outputs decoded from the upcoming state
    always_comb begin
        rdy_d    = (state_d == IDLE);
        busy_d   = (state_d != IDLE);
        clr_d    = (state_d == CLEAR);
        rv_d     = (state_d == OUTPUT);
        rd_d     = (state_d == FEED) && (t_d < TW'(k_q));
        lane_d   = (state_d == FEED) ? lane_mask_c : '0;
        a_addr_d = rd_d ? (a_base_q + ADDR_WIDTH'(t_d)) : a_addr_q;
        b_addr_d = rd_d ? (b_base_q + ADDR_WIDTH'(t_d)) : b_addr_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q  <= IDLE;
            t_q      <= '0;
            k_q      <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            drain_q  <= '0;
            row_q    <= '0;
            lane_q   <= '0;
            done_q   <= 1'b0;
            clr_q    <= 1'b0;
            rd_q     <= 1'b0;
            rv_q     <= 1'b0;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            k_q      <= k_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
            a_addr_q <= a_addr_d;
            b_addr_q <= b_addr_d;
            drain_q  <= drain_d;
            row_q    <= row_d;
            lane_q   <= lane_d;
            done_q   <= done_d;
            clr_q    <= clr_d;
            rd_q     <= rd_d;
            rv_q     <= rv_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.start_ready_o = rdy_q;
    assign bus.pe_clear_o    = clr_q;
    assign bus.rd_en_o       = rd_q;
    assign bus.a_addr_o      = a_addr_q;
    assign bus.b_addr_o      = b_addr_q;
    assign bus.lane_en_o     = lane_q;
    assign bus.result_v_o    = rv_q;
    assign bus.result_row_o  = row_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;

endmodule

// File: tb/tb_sa_mm_sequencer.sv
// Scoreboard bench: each job pushes its expected per-cycle activity, a monitor
// pops and compares every cycle in which the sequencer shows any activity.
module tb_sa_mm_sequencer;

    localparam int AS = 4;
    localparam int KW = 8;
    localparam int AW = 8;
    localparam int DC = 4;

    logic clk_i = 1'b1;
    logic reset;
    always #5 clk_i = ~clk_i;

    sa_mm_sequencer_if #(.ARRAY_SIZE(AS), .K_WIDTH(KW), .ADDR_WIDTH(AW)) bus ();

    sa_mm_sequencer #(
        .ARRAY_SIZE(AS), .K_WIDTH(KW), .ADDR_WIDTH(AW), .DRAIN_CYCLES(DC)
    ) dut (
        .clk_i (clk_i),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int cyc;
        bit clr;
        bit rd;
        int a;
        int b;
        int lane;
        bit rv;
        int row;
        bit done;
        bit busy;
    } ev_t;

    ev_t exp_q[$];
    ev_t e;
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  init_rst = 1'b1;
    int  rdy_lo = -1, rdy_hi = -1, abort_cyc = -1, rst_cyc = -1;
    bit  ok;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Cycle-indexed drive of reset, result backpressure and abort
    always @(negedge clk_i) begin
        reset              = init_rst || (cyc == rst_cyc);
        bus.result_ready_i = !((cyc >= rdy_lo) && (cyc < rdy_hi));
        bus.abort_i        = (cyc == abort_cyc);
    end

    always @(negedge clk_i) begin
        if (!init_rst && (bus.pe_clear_o || bus.rd_en_o || (bus.lane_en_o != '0) ||
                          bus.result_v_o || bus.done_o)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_activity cyc=%0d clr=%b rd=%b lane=%b rv=%b row=%0d done=%b",
                         cyc, bus.pe_clear_o, bus.rd_en_o, bus.lane_en_o, bus.result_v_o,
                         bus.result_row_o, bus.done_o);
            end else begin
                e  = exp_q.pop_front();
                ok = (cyc == e.cyc) && (bus.pe_clear_o == e.clr) && (bus.rd_en_o == e.rd) &&
                     (!e.rd || ((int'(bus.a_addr_o) == e.a) && (int'(bus.b_addr_o) == e.b))) &&
                     (int'(bus.lane_en_o) == e.lane) && (bus.result_v_o == e.rv) &&
                     (!e.rv || (int'(bus.result_row_o) == e.row)) && (bus.done_o == e.done) &&
                     (bus.busy_o == e.busy) && (bus.start_ready_o == !e.busy);
                if (!ok)  begin
                    errors++;
                    $display("FAIL activity got cyc=%0d clr=%b rd=%b a=%h b=%h lane=%b rv=%b row=%0d done=%b busy=%b rdy=%b | exp cyc=%0d clr=%b rd=%b a=%h b=%h lane=%b rv=%b row=%0d done=%b busy=%b",
                             cyc, bus.pe_clear_o, bus.rd_en_o, bus.a_addr_o, bus.b_addr_o,
                             bus.lane_en_o, bus.result_v_o, bus.result_row_o, bus.done_o,
                             bus.busy_o, bus.start_ready_o, e.cyc, e.clr, e.rd, e.a[7:0],
                             e.b[7:0], e.lane[3:0], e.rv, e.row, e.done, e.busy);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic push_ev(input int cut, input int c0, input int off, input bit clr,
                           input bit rd, input int a, input int b, input int lane,
                           input bit rv, input int row, input bit done, input bit busy);
        ev_t x;
        if (cut >= 0 && off > cut) return;
        x.cyc = c0 + off; x.clr = clr; x.rd = rd; x.a = a; x.b = b; x.lane = lane;
        x.rv = rv; x.row = row; x.done = done; x.busy = busy;
        exp_q.push_back(x);
    endtask

    // Expected timeline of one job relative to its handshake cycle c0
    task automatic push_job(input int c0, input int k, input int a, input int b,
                            input int stall_row, input int stall_len, input int cut);
        int off, lane;
        if (k == 0) begin
            push_ev(cut, c0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            return;
        end
        push_ev(cut, c0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int t = 0; t <= k + AS - 2; t++) begin
            lane = 0;
            for (int r = 0; r < AS; r++)
                if (t >= r && t - r < k) lane |= (1 << r);
            push_ev(cut, c0, 2 + t, 0, (t < k), (a + t) % 256, (b + t) % 256, lane,
                    0, 0, 0, 1);
        end
        off = k + AS + DC + 1;
        for (int r = 0; r < AS; r++) begin
            for (int n = 0; n <= ((r == stall_row) ? stall_len : 0); n++) begin
                push_ev(cut, c0, off, 0, 0, 0, 0, 0, 1, r, 0, 1);
                off++;
            end
        end
        push_ev(cut, c0, off, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    // cut_kind: 0 none, 1 abort at offset cut_off, 2 reset at offset cut_off
    task automatic start_job(input int k, input int a, input int b, input int stall_row,
                             input int stall_len, input int cut_kind, input int cut_off,
                             output int c0);
        int n;
        @(negedge clk_i);
        bus.start_v_i = 1'b1;
        bus.k_len_i   = KW'(k);
        bus.a_base_i  = AW'(a);
        bus.b_base_i  = AW'(b);
        n = 0;
        while (bus.start_ready_o !== 1'b1 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL start_timeout got=no_ready exp=ready k=%0d", k);
        end
        c0 = cyc;
        push_job(c0, k, a, b, stall_row, stall_len, (cut_kind != 0) ? cut_off : -1);
        if (stall_row >= 0) begin
            rdy_lo = c0 + k + AS + DC + 1 + stall_row;
            rdy_hi = rdy_lo + stall_len;
        end
        if (cut_kind == 1) abort_cyc = c0 + cut_off;
        if (cut_kind == 2) rst_cyc   = c0 + cut_off;
        @(negedge clk_i);
        bus.start_v_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.start_ready_o !== 1'b1 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout got=busy exp=idle");
        end
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        int c0, c1;
        bus.start_v_i = 1'b0;
        bus.k_len_i   = '0;
        bus.a_base_i  = '0;
        bus.b_base_i  = '0;
        repeat (4) @(negedge clk_i);
        chk("rst_start_ready", int'(bus.start_ready_o), 1);
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_strobes", int'({bus.pe_clear_o, bus.rd_en_o, bus.result_v_o, bus.done_o}), 0);
        chk("rst_lane_row", int'({bus.lane_en_o, bus.result_row_o}), 0);
        chk("rst_addr", int'({bus.a_addr_o, bus.b_addr_o}), 0);
        init_rst = 1'b0;
        repeat (2) @(negedge clk_i);

        // Skew pattern
        start_job(3, 'h10, 'h20, -1, 0, 0, 0, c0);
        wait_idle();
        // Backpressure on row 1
        start_job(3, 'h10, 'h20, 1, 3, 0, 0, c0);
        wait_idle();
        // Zero-length job
        start_job(0, 'h05, 'h06, -1, 0, 0, 0, c0);
        repeat (3) @(negedge clk_i);
        // Address wrap
        start_job(4, 'hFE, 'h30, -1, 0, 0, 0, c0);
        wait_idle();
        // Abort at FEED t=2, then a clean job
        start_job(3, 'h40, 'h50, -1, 0, 1, 4, c0);
        start_job(2, 'h60, 'h70, -1, 0, 0, 0, c1);
        chk("abort_next_accept_cycle", c1, c0 + 5);
        wait_idle();
        // Reset while offering row 1, then a clean job
        start_job(2, 'h80, 'h90, -1, 0, 2, 2 + AS + DC + 2, c0);
        start_job(1, 'hA0, 'hB0, -1, 0, 0, 0, c1);
        chk("reset_next_accept_cycle", c1, c0 + 2 + AS + DC + 3);
        wait_idle();
        // Back-to-back: second start held high, taken in the done cycle
        start_job(2, 'h01, 'h02, -1, 0, 0, 0, c0);
        start_job(1, 'h03, 'h04, -1, 0, 0, 0, c1);
        chk("b2b_accept_cycle", c1, c0 + 2 + AS + DC + 1 + AS);
        wait_idle();

        repeat (20) @(negedge clk_i);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
